ddr_param_reader: RTL and testbench
===================================

Name: ddr_param_reader

Overview:
- Upstream feeder for the parameter-buffer loader. Turns one transfer configuration (base byte address, beat count) into DDR read bursts.
- Collects the returned beats into an internal FIFO and presents them, in order, as a valid/ready stream on the loader's ddr2 data port.
- Credit-based burst issue guarantees the FIFO never overflows, so the DDR read-data channel is never back-pressured.

Parameters:
- DDR_W, 512, width of one DDR data beat in bits (8-bit bytes; DDR_W/8 bytes per beat).
- AXI_AW, 32, DDR byte-address width.
- MAX_BURST, 16, maximum beats per read burst (power of 2, <=256).
- FIFO_DEPTH, 64, beat capacity of the return FIFO (power of 2, >= MAX_BURST).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- conf_valid  in  1  configuration request
- conf_ready  out  1  block idle, configuration accepted when conf_valid && conf_ready
- conf_base_addr  in  AXI_AW  start byte address, aligned to DDR_W/8
- conf_beat_num  in  12  number of beats to transfer
- ar_addr  out  AXI_AW  burst start byte address
- ar_len  out  8  burst length minus 1
- ar_valid  out  1  read-address request
- ar_ready  in  1  read-address accept
- r_data  in  DDR_W  returned beat
- r_valid  in  1  returned beat valid
- r_last  in  1  last beat of a burst
- r_ready  out  1  constant 1
- out_data  out  DDR_W  stream data to loader
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- err  out  1  sticky r_last protocol error

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset values: conf_ready=1, ar_valid=0, ar_addr=0, ar_len=0, out_valid=0, err=0. FIFO empty, all counters 0.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: conf_ready=1. On accept, latch addr and remaining beats = conf_beat_num, clear err, go to ISSUE. conf_beat_num=0 goes straight back to IDLE next cycle; no burst is issued.
  - ISSUE: conf_ready=0. When remaining=0 and ar_valid=0, go to DRAIN.
  - DRAIN: wait until the outstanding count is 0 and the FIFO is empty (last beat consumed), then go to IDLE. conf_ready rises the cycle after the last out handshake.
- Burst length: len = min(MAX_BURST, remaining, beats left to the next 4 KiB boundary). A burst never crosses a 4 KiB address boundary.
- Burst issue:
  - Credit rule: fifo_count + outstanding + len <= FIFO_DEPTH, evaluated the cycle before ar_valid is raised. Credit is reserved when ar_valid is raised.
  - ar_addr and ar_len are registered and held stable while ar_valid=1 && ar_ready=0.
  - On ar handshake: addr += len*DDR_W/8; remaining -= len; outstanding += len.
  - Next request may be raised the cycle after a handshake. At most one ar per 2 cycles is acceptable.
- Return path:
  - Every r_valid beat is written to the FIFO. Each beat moves one credit from outstanding to fifo_count.
  - out_valid rises exactly 1 cycle after the first beat's r_valid. Order is preserved.
  - Simultaneous FIFO write and read in the same cycle leaves the count unchanged.
  - Full FIFO with r_valid cannot occur under the credit rule. The bench asserts it never happens.
- Protocol check: a per-burst beat counter is compared against the head of an in-order queue of issued lens (depth FIFO_DEPTH/1 min 4; ar issue also stalls while the queue is full).
  - r_last on a non-final beat, or a missing r_last on the final beat, sets err. err stays set until the next accepted configuration.
  - The beat is still stored.
- conf_valid while busy is ignored; configuration is never latched mid-transfer.
- Reset mid-operation: FSM returns to IDLE, the FIFO is flushed, ar_valid=0, outstanding=0. In-flight returned beats after reset are not this block's concern; the system resets DDR together with it.
- Arithmetic: counters are 12 bits (13 bits for fifo_count+outstanding+len comparison). Address arithmetic wraps modulo 2^AXI_AW.

Test Plan:
- base=0x1000, beats=5, ar_ready=1, r returns 5 beats with r_last on the 5th, out_ready=1 -> single ar(len=4, addr 0x1000); 5 out beats in order, each 1 cycle after r_valid; conf_ready=1 one cycle after the last out beat; err=0.
- base=0x0F80 (2 beats before a 4 KiB boundary at DDR_W=512), beats=40 -> ar sequence (0x0F80,len 1),(0x1000,len 15),(0x1400,len 15),(0x1800,len 5); 40 out beats in order.
- beats=200, out_ready=0 for 300 cycles -> ar issue stops once 64 beats are reserved; no beat lost. On release all 200 beats are output, no overflow assertion, and the final conf_ready=1.
- ar_ready held low 10 cycles on the first request -> ar_addr and ar_len stable throughout; no second ar before the handshake.
- conf_beat_num=0 -> no ar_valid; conf_ready back to 1 two cycles after accept. A burst of len 3 with r_last on beat 2 -> err=1, cleared by the next configuration.
- rst asserted mid-transfer after 2 of 4 bursts -> next cycle ar_valid=0, out_valid=0, conf_ready=1; a new transfer then completes normally.

Source files
------------

// File: rtl/ddr_param_reader.sv
// ddr_param_reader: turns one (base address, beat count) transfer into 4 KiB-safe DDR read bursts and streams the returned beats in order
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   conf_valid/conf_ready            transfer request; ready only while idle
//   conf_base_addr, conf_beat_num    start byte address and number of beats
//   ar_addr, ar_len, ar_valid/ready  DDR read-address channel (ar_len = beats - 1)
//   r_data, r_valid, r_last, r_ready DDR read-data channel (never back-pressured)
//   out_data, out_valid/out_ready    in-order beat stream towards the loader
//   err                              sticky r_last protocol error, cleared by the next transfer
module ddr_param_reader #(
    parameter int DDR_W      = 512,
    parameter int AXI_AW     = 32,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              conf_valid,
    output logic              conf_ready,
    input  logic [AXI_AW-1:0] conf_base_addr,
    input  logic [11:0]       conf_beat_num,
    output logic [AXI_AW-1:0] ar_addr,
    output logic [7:0]        ar_len,
    output logic              ar_valid,
    input  logic              ar_ready,
    input  logic [DDR_W-1:0]  r_data,
    input  logic              r_valid,
    input  logic              r_last,
    output logic              r_ready,
    output logic [DDR_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err
);
    localparam int BW = $clog2(DDR_W / 8);
    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state_q, state_d;

    logic [AXI_AW-1:0] addr_q, ar_addr_q, ar_addr_d;
    logic [11:0]       rem_q, outst_q, outst_d, cnt_q, cnt_d, hs_len;
    logic [7:0]        ar_len_q, ar_len_d, bcnt_q;
    logic              ar_valid_q, ar_valid_d, err_q;
    logic [PW-1:0]     wp_q, rp_q, lwp_q, lrp_q;
    logic [PW:0]       lcnt_q;
    logic [DDR_W-1:0]  mem [FIFO_DEPTH];
    logic [7:0]        lq [FIFO_DEPTH];
    logic [12:0]       bnd, cap, len;
    logic              accept, hs, pop, lpop, raise, drained;

    always_comb begin
        accept     = state_q == IDLE && conf_valid;
        hs         = ar_valid_q && ar_ready;
        hs_len     = 12'(ar_len_q) + 12'd1;
        pop        = cnt_q != 12'd0 && out_ready;
        // a beat closes the burst at the head of the issued-length queue
        lpop       = r_valid && lcnt_q != '0 && bcnt_q == lq[lrp_q];
        // beats left before the next 4 KiB boundary
        bnd        = 13'(4096 >> BW) - 13'(addr_q[11:0] >> BW);
        cap        = rem_q < 12'(MAX_BURST) ? {1'b0, rem_q} : 13'(MAX_BURST);
        len        = bnd < cap ? bnd : cap;
        cnt_d      = cnt_q + 12'(r_valid) - 12'(pop);
        outst_d    = outst_q + (hs ? hs_len : 12'd0) - 12'(r_valid);
        drained    = cnt_d == 12'd0 && outst_d == 12'd0;
        // credit: every beat that can still arrive must already have a FIFO slot
        raise      = state_q == ISSUE && !ar_valid_q && rem_q != 12'd0 && !lcnt_q[PW]
                     && 13'(cnt_q) + 13'(outst_q) + len <= 13'(FIFO_DEPTH);
        ar_valid_d = raise || (ar_valid_q && !ar_ready);
        ar_addr_d  = raise ? addr_q : ar_addr_q;
        ar_len_d   = raise ? 8'(len - 13'd1) : ar_len_q;
        state_d    = state_q == IDLE  ? (conf_valid ? ISSUE : IDLE) :
                     state_q == ISSUE ? (rem_q == 12'd0 && !ar_valid_q ? (drained ? IDLE : DRAIN) : ISSUE) :
                                        (drained ? IDLE : DRAIN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            outst_q    <= '0;
            cnt_q      <= '0;
            ar_valid_q <= 1'b0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            bcnt_q     <= '0;
            err_q      <= 1'b0;
            wp_q       <= '0;
            rp_q       <= '0;
            lwp_q      <= '0;
            lrp_q      <= '0;
            lcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= accept ? conf_base_addr : hs ? addr_q + (AXI_AW'(hs_len) << BW) : addr_q;
            rem_q      <= accept ? conf_beat_num : hs ? rem_q - hs_len : rem_q;
            outst_q    <= outst_d;
            cnt_q      <= cnt_d;
            ar_valid_q <= ar_valid_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            bcnt_q     <= !r_valid ? bcnt_q : lpop ? 8'd0 : bcnt_q + 8'd1;
            err_q      <= accept ? 1'b0 : err_q || (r_valid && (lcnt_q == '0 || r_last != lpop));
            wp_q       <= wp_q + PW'(r_valid);
            rp_q       <= rp_q + PW'(pop);
            lwp_q      <= lwp_q + PW'(hs);
            lrp_q      <= lrp_q + PW'(lpop);
            lcnt_q     <= lcnt_q + (PW+1)'(hs) - (PW+1)'(lpop);
        end
    end

    always_ff @(posedge clk) begin
        if (r_valid) mem[wp_q] <= r_data;
        if (hs) lq[lwp_q] <= ar_len_q;
    end

    assign conf_ready = state_q == IDLE;
    assign ar_addr    = ar_addr_q;
    assign ar_len     = ar_len_q;
    assign ar_valid   = ar_valid_q;
    assign r_ready    = 1'b1;
    assign out_data   = mem[rp_q];
    assign out_valid  = cnt_q != 12'd0;
    assign err        = err_q;
endmodule

// File: tb/tb_ddr_param_reader.sv
// tb_ddr_param_reader: randomized DDR slave and loader sink checked against a queue-based reference model
module tb_ddr_param_reader;
    localparam int DDR_W      = 512;
    localparam int AXI_AW     = 32;
    localparam int MAX_BURST  = 16;
    localparam int FIFO_DEPTH = 64;
    localparam int BYTES      = DDR_W / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              conf_valid, conf_ready;
    logic [AXI_AW-1:0] conf_base_addr, ar_addr;
    logic [11:0]       conf_beat_num;
    logic [7:0]        ar_len;
    logic              ar_valid, ar_ready, r_valid, r_last, r_ready, out_valid, out_ready, err;
    logic [DDR_W-1:0]  r_data, out_data;

    int n_chk = 0, n_fail = 0;
    logic [DDR_W-1:0]  exp_q[$];
    logic [AXI_AW-1:0] ea_addr[$];
    int                ea_len[$];
    int                pend[$];
    int                issued = 0, popped = 0, outs = 0, hs_cnt = 0, cyc = 0, rise = 0, last_pop = 0;
    int                ar_hold = 0, bidx = 0;
    bit                rnd = 0, inject = 0, bad = 0, stall = 0, cr_prev = 0;
    logic [1:0]        omode = 2'd1;
    logic [AXI_AW-1:0] s_addr;
    logic [7:0]        s_len;

    ddr_param_reader #(.DDR_W(DDR_W), .AXI_AW(AXI_AW), .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .conf_valid(conf_valid), .conf_ready(conf_ready),
        .conf_base_addr(conf_base_addr), .conf_beat_num(conf_beat_num),
        .ar_addr(ar_addr), .ar_len(ar_len), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_data(r_data), .r_valid(r_valid), .r_last(r_last), .r_ready(r_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DDR_W-1:0] got, input logic [DDR_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nclk;
        @(negedge clk);
        #1;
    endtask

    // expected bursts straight from the rules: min(MAX_BURST, remaining, beats to 4 KiB)
    task automatic plan(input logic [AXI_AW-1:0] base, input int n);
        logic [AXI_AW-1:0] a = base;
        int r = n;
        while (r > 0) begin
            int l = MAX_BURST;
            int b = (4096 - int'(a % 4096)) / BYTES;
            if (r < l) l = r;
            if (b < l) l = b;
            ea_addr.push_back(a);
            ea_len.push_back(l);
            a += AXI_AW'(l * BYTES);
            r -= l;
        end
    endtask

    task automatic start(input logic [AXI_AW-1:0] base, input int n);
        plan(base, n);
        outs = 0;
        hs_cnt = 0;
        @(posedge clk);
        #1;
        conf_valid = 1'b1;
        conf_base_addr = base;
        conf_beat_num = 12'(n);
        @(posedge clk);
        #1;
        conf_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        int k = 0;
        do begin
            nclk();
            k++;
        end while (!conf_ready && k < 4000);
        chk("done", conf_ready, 1);
        chk("beats_out", outs, n);
        chk("ar_left", ea_addr.size(), 0);
        chk("fifo_left", exp_q.size(), 0);
    endtask

    // DDR slave and loader sink
    initial begin
        ar_ready = 1'b0;
        r_valid = 1'b0;
        r_last = 1'b0;
        r_data = '0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                ar_ready = 1'b0;
                r_valid = 1'b0;
                r_last = 1'b0;
                bidx = 0;
            end else begin
                if (ar_hold > 0 && ar_valid) begin
                    ar_ready = 1'b0;
                    ar_hold--;
                end else ar_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (pend.size() != 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                    if (bidx == 0) begin
                        bad = inject;
                        inject = 0;
                    end
                    r_valid = 1'b1;
                    for (int i = 0; i < DDR_W / 32; i++) r_data[i*32 +: 32] = $urandom;
                    r_last = bad ? (bidx == 1) : (bidx == pend[0]);
                    if (bidx == pend[0]) begin
                        void'(pend.pop_front());
                        bidx = 0;
                    end else bidx++;
                end else begin
                    r_valid = 1'b0;
                    r_last = 1'b0;
                end
            end
            out_ready = omode == 2'd2 ? 1'($urandom_range(0, 1)) : omode[0];
        end
    end

    // reference model: returned beats queue up, leave in order, one cycle after arrival
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            ea_addr.delete();
            ea_len.delete();
            pend.delete();
            issued = 0;
            popped = 0;
            stall = 0;
        end else begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            if (r_valid) chk("no_ovf", exp_q.size() < FIFO_DEPTH, 1);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                chk("out_data", out_data, exp_q.pop_front());
                popped++;
                outs++;
                last_pop = cyc;
            end
            if (r_valid) exp_q.push_back(r_data);
            if (stall) chk("ar_hold", ar_valid, 1);
            if (stall && ar_valid) begin
                chk("ar_addr_hold", ar_addr, s_addr);
                chk("ar_len_hold", ar_len, s_len);
            end
            stall = ar_valid && !ar_ready;
            s_addr = ar_addr;
            s_len = ar_len;
            if (ar_valid && ar_ready) begin
                chk("ar_avail", ea_addr.size() != 0, 1);
                if (ea_addr.size() != 0) begin
                    chk("ar_addr", ar_addr, ea_addr.pop_front());
                    chk("ar_len", ar_len, ea_len.pop_front() - 1);
                end
                pend.push_back(int'(ar_len));
                issued += int'(ar_len) + 1;
                hs_cnt++;
                chk("credit", issued - popped <= FIFO_DEPTH, 1);
            end
            if (conf_ready && !cr_prev) rise = cyc;
        end
        cr_prev = conf_ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        conf_valid = 1'b0;
        conf_base_addr = '0;
        conf_beat_num = '0;
        repeat (3) @(posedge clk);
        nclk();
        chk("rst_conf_ready", conf_ready, 1);
        chk("rst_ar_valid", ar_valid, 0);
        chk("rst_ar_addr", ar_addr, 0);
        chk("rst_ar_len", ar_len, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        start(32'h1000, 5);
        wait_done(5);
        chk("rdy_lat", rise - last_pop, 1);
        chk("t1_err", err, 0);

        rnd = 1;
        omode = 2'd2;
        start(32'h0F80, 40);
        wait_done(40);

        omode = 2'd0;
        start(32'h0, 200);
        repeat (300) @(posedge clk);
        nclk();
        chk("reserved", issued - popped, FIFO_DEPTH);
        chk("fifo_held", exp_q.size(), FIFO_DEPTH);
        chk("held_valid", out_valid, 1);
        omode = 2'd2;
        wait_done(200);

        ar_hold = 10;
        start(32'h2000, 20);
        wait_done(20);

        start(32'h100, 0);
        nclk();
        chk("zero_busy", conf_ready, 0);
        chk("zero_no_ar", ar_valid, 0);
        nclk();
        chk("zero_ready", conf_ready, 1);
        chk("zero_no_ar2", ar_valid, 0);

        inject = 1;
        start(32'h3000, 3);
        wait_done(3);
        chk("err_set", err, 1);
        start(32'h3000, 3);
        nclk();
        chk("err_clr", err, 0);
        wait_done(3);
        chk("err_stay0", err, 0);

        start(32'h0, 64);
        for (k = 0; k < 2000 && hs_cnt < 2; k++) nclk();
        chk("two_bursts", hs_cnt >= 2, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        nclk();
        nclk();
        chk("mid_rst_ar_valid", ar_valid, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_conf_ready", conf_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start(32'h5000, 30);
        wait_done(30);
        chk("final_err", err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
